// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Exports: NUM_DIGITS_DEF, ANODE_OFF, scan_state_e, anode_for().
package seg7_scan_pkg;

  localparam int NUM_DIGITS_DEF = 8;
  localparam int MAX_DIGITS     = 32;

  localparam logic [NUM_DIGITS_DEF-1:0] ANODE_OFF = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LIT   = 2'd1,
    S_GUARD = 2'd2
  } scan_state_e;

  // Active-low one-hot anode; callers slice to their width.
  function automatic logic [MAX_DIGITS-1:0] anode_for(
    input int unsigned idx
  );
    logic [MAX_DIGITS-1:0] one;
    one = MAX_DIGITS'(1);
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Terminal-count phase timer shared by the LIT and GUARD phases.
// Ports: clk, rst_n (sync, active-low), clr, term (last count), done.
module seg7_scan_timer #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == term);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned word load.
// Ports: clk, rst_n, en, load/value/ready, blank_mask -> n, seg_en, anode, frame_done.
module seg7_scan_ctrl
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2,
  parameter int CNT_W        = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic                    ready,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              n,
  output logic                    seg_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LIT_TERM = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GRD_TERM =
    CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  scan_state_e st, st_n;
  logic [IDX_W-1:0] idx, idx_n, idx_inc;
  logic [4*NUM_DIGITS-1:0] word, word_n, shadow;
  logic pending;
  logic t_clr, t_done;
  logic [CNT_W-1:0] t_term;
  logic period_end, wrap, commit, accept;
  logic lit_n, vis_n;
  logic [MAX_DIGITS-1:0] anode_full;
  logic [NUM_DIGITS-1:0] anode_d;
  logic [3:0] n_d;

  seg7_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (t_clr),
    .term  (t_term),
    .done  (t_done)
  );

  always_comb begin
    idx_inc = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    t_term  = (st == S_GUARD) ? GRD_TERM : LIT_TERM;
    period_end = t_done &&
      ((st == S_GUARD) || (st == S_LIT && GUARD_CYCLES == 0));
    // Wrap is judged before en, so a falling en still commits and pulses.
    wrap    = period_end && (idx == IDX_LAST);
    commit  = pending && (wrap || st == S_IDLE);
    accept  = load && ready;
    word_n  = commit ? shadow : word;

    st_n  = st;
    idx_n = idx;
    t_clr = 1'b0;
    unique case (st)
      S_IDLE: begin
        t_clr = 1'b1;
        if (en) begin
          st_n  = S_LIT;
          idx_n = '0;
        end
      end
      S_LIT: begin
        if (t_done) begin
          t_clr = 1'b1;
          if (GUARD_CYCLES == 0) idx_n = idx_inc;
          else st_n = S_GUARD;
        end
      end
      S_GUARD: begin
        if (t_done) begin
          t_clr = 1'b1;
          st_n  = S_LIT;
          idx_n = idx_inc;
        end
      end
      default: begin
        t_clr = 1'b1;
        st_n  = S_IDLE;
      end
    endcase
    if (!en) begin
      st_n  = S_IDLE;
      idx_n = '0;
      t_clr = 1'b1;
    end

    // Outputs are registered from next-state values so they align with st.
    lit_n      = (st_n == S_LIT);
    vis_n      = lit_n && !blank_mask[idx_n];
    anode_full = anode_for(32'(idx_n));
    anode_d    = vis_n ? anode_full[NUM_DIGITS-1:0] : '1;
    n_d        = lit_n ? word_n[4*idx_n +: 4] : n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      idx        <= '0;
      word       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      ready      <= 1'b1;
      anode      <= '1;
      n          <= '0;
      seg_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      st         <= st_n;
      idx        <= idx_n;
      word       <= word_n;
      anode      <= anode_d;
      n          <= n_d;
      seg_en     <= vis_n;
      frame_done <= wrap;
      if (commit) begin
        pending <= 1'b0;
        ready   <= 1'b1;
      end else if (accept) begin
        shadow  <= value;
        pending <= 1'b1;
        ready   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexing scan controller for the 8-digit seven-segment display.
- Rotates the active anode and presents the matching 4-bit digit nibble to the hex-to-segment decoder, with that decoder's enable tied high.
- Holds a 32-bit display word loaded through a ready/valid-style handshake. The word commits only at frame boundaries, so a frame never shows a mix of old and new digits.
- Inserts blank guard cycles between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; anode width; display word = 4*NUM_DIGITS bits.
- REFRESH_DIV, 100000, clock cycles each digit is lit.
- GUARD_CYCLES, 2, all-anodes-off cycles between digits; 0 removes the guard phase.
- CNT_W, 17, counter width; must hold max(REFRESH_DIV, GUARD_CYCLES).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  scan enable; 0 = display dark
- load  in  1  request to load value
- value  in  4*NUM_DIGITS  new display word; digit i = value[4i+3:4i]
- ready  out  1  load accepted when load & ready
- blank_mask  in  NUM_DIGITS  1 = digit i never lit (leading-zero blanking)
- n  out  4  nibble to decoder
- seg_en  out  1  1 while a digit is lit
- anode  out  NUM_DIGITS  active-low anode drive
- frame_done  out  1  one-cycle pulse after last digit's guard

Behaviour:
- Clocking and reset:
  - Single clock; rst_n is sampled only on the rising edge of clk.
  - All outputs are registered.
  - Reset values: anode all 1s; n = 0; seg_en = 0; ready = 1; frame_done = 0. Internal display word = 0, shadow = 0, pending = 0, digit index = 0, counter = 0, state = IDLE.
- States: IDLE, LIT, GUARD.
- IDLE:
  - anode all 1s; seg_en = 0.
  - en = 1 moves to LIT on the next edge with index 0 and counter 0.
  - A pending word commits on the cycle after it is accepted.
- LIT:
  - anode = all 1s except bit[index] = 0. If blank_mask[index] = 1, anode stays all 1s and seg_en = 0.
  - n = display word nibble[index]; seg_en = ~blank_mask[index].
  - Counter increments each cycle. At REFRESH_DIV-1 the counter clears and the state moves to GUARD, or directly to the next digit when GUARD_CYCLES = 0.
- GUARD:
  - anode all 1s; seg_en = 0; n holds its value.
  - After GUARD_CYCLES cycles: index increments and the state returns to LIT.
- Frame wrap:
  - Occurs when the index is NUM_DIGITS-1 as the digit period ends.
  - Index wraps to 0 and frame_done pulses high for exactly one cycle, coincident with digit 0's first LIT cycle.
  - If pending = 1: display word <= shadow, pending <= 0, ready <= 1, all on the same edge. Digit 0 of the new frame shows the new word.
- Load handshake:
  - load & ready on an edge: shadow <= value, pending <= 1, ready <= 0 from the next cycle.
  - load while ready = 0 is ignored; the requester must hold or retry.
  - At most one word is outstanding.
- Timing:
  - Digit period = REFRESH_DIV + GUARD_CYCLES cycles.
  - Frame period = NUM_DIGITS x digit period.
  - Load-to-visible latency ≤ 1 frame + 1 cycle while scanning.
- Disable mid-operation:
  - en = 0 in any state: the next edge forces IDLE, anode all 1s, index 0 and counter 0.
  - No frame_done pulse is produced.
  - A pending word commits in IDLE.
- Simultaneous events:
  - Commit and load in the same cycle cannot both occur, because ready = 0 while pending.
  - en falling on the wrap cycle: the wrap commit happens; frame_done still pulses; the next state is IDLE.
- Reset mid-frame: immediate return to reset values; pending word discarded.

Decomposition:
- Shared display package holds:
  - constants NUM_DIGITS_DEF = 8 and ANODE_OFF = all 1s;
  - a scan-state enum (IDLE, LIT, GUARD);
  - a function returning the one-hot active-low anode for a given index.
- One natural sub-module: seg7_scan_timer, a CNT_W-bit terminal-count counter with clear and a done flag. It is used for both the LIT and GUARD phases.
- The existing decoder is instantiated at top level, not inside this block.

Test Plan:
All scenarios use REFRESH_DIV = 4, GUARD_CYCLES = 1, NUM_DIGITS = 8, so the digit period is 5 cycles and the frame is 40 cycles.
- Reset: hold rst_n = 0 for 3 cycles with en = 1 → anode = 8'hFF, seg_en = 0, ready = 1, frame_done = 0. Release → digit 0 lit one cycle later with anode = 8'hFE.
- Scan order: en = 1, word 0 → anode sequence FE×4, FF×1, FD×4, FF, … 7F×4, FF. frame_done pulses at cycle 40, then the sequence repeats.
- Handshake: load = 1, value = 32'h76543210 mid-frame → ready falls the next cycle; the old word is shown until wrap. After wrap: n = 0 on digit 0, … n = 7 on digit 7; ready = 1. A second load while ready = 0 has no effect.
- Blanking: blank_mask = 8'hF0 → anode stays FF and seg_en = 0 during digit slots 4–7. Frame length is still 40 cycles.
- Disable: drop en at digit 3 → anode = FF the next cycle and no frame_done. Re-enable → scan restarts at digit 0.
- Guard-free: GUARD_CYCLES = 0 → no FF cycles between digits; frame = 32 cycles.
